// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner
//   Conditions the raw board switches for the RISC_8bit core's sw[7:0] port.
//   Each bit is synchronised into the clk domain and debounced on its own.
//   A startup sequence fills the synchronisers and then loads the switch word
//   directly, so the core sees the real switch positions without a debounce
//   delay and without a spurious change event.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   sw_raw     in   WIDTH  asynchronous switch pins
//   sw_clean   out  WIDTH  debounced switch word (feeds the core's sw)
//   sw_valid   out  1      high once sw_clean reflects the switches after reset
//   sw_changed out  1      one-cycle pulse when sw_clean changes while running
//   sw_rise    out  WIDTH  bits that went 0->1 during the sw_changed cycle
//   sw_fall    out  WIDTH  bits that went 1->0 during the sw_changed cycle
module sw_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_valid,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int INIT_W = $clog2(SYNC_STAGES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {S_INIT, S_LOAD, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic              load_en;
  logic              run_en;

  logic [WIDTH-1:0]  sync_p [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_out;

  logic [WIDTH-1:0]  stable, stable_nxt;
  logic [CNT_W-1:0]  cnt     [WIDTH];
  logic [CNT_W-1:0]  cnt_nxt [WIDTH];

  // ---- synchroniser chain: shifts every cycle, whatever the FSM state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync_out = sync_p[SYNC_STAGES-1];

  // ---- startup FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT && init_cnt != INIT_LAST)
        init_cnt <= init_cnt + INIT_W'(1);
    end
  end

  // ---- startup FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == INIT_LAST) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // ---- startup FSM: outputs ----
  always_comb begin
    load_en  = (state == S_LOAD);
    run_en   = (state == S_RUN);
    sw_valid = (state == S_RUN);
  end

  // ---- per-bit debounce decision ----
  // A bit only moves after DEBOUNCE_CYCLES consecutive mismatching cycles;
  // any agreement in between restarts the count from zero.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) cnt_nxt[i] = cnt[i];
    if (load_en) begin
      stable_nxt = sync_out;
    end else if (run_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == stable[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync_out[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- stable word, counters and event outputs ----
  // Events are registered alongside stable so they line up with sw_clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable     <= '0;
      sw_changed <= 1'b0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable     <= stable_nxt;
      sw_changed <= run_en && (stable_nxt != stable);
      sw_rise    <= run_en ? (stable_nxt & ~stable) : '0;
      sw_fall    <= run_en ? (~stable_nxt & stable) : '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign sw_clean = stable;

endmodule

// File: tb/tb_sw_input_conditioner.sv
module tb_sw_input_conditioner;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic         sw_valid;
  logic         sw_changed;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  always #5 clk = ~clk;

  sw_input_conditioner #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_valid  (sw_valid),
    .sw_changed(sw_changed),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the last SS raw samples since reset form the
  // synchroniser delay; each bit remembers how long the delayed input has
  // disagreed with the accepted value.
  logic [W-1:0] mq[$];
  int           n_edges;
  int           run_len [W];
  logic [W-1:0] m_clean = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  logic         m_valid = 1'b0;
  logic         m_chg   = 1'b0;

  // Observed events (sw_changed cycles) for directed checks.
  logic [W-1:0] ev_rise[$];
  logic [W-1:0] ev_fall[$];
  int           ev_cyc[$];

  task automatic model_edge(input logic r, input logic [W-1:0] raw);
    logic [W-1:0] so;
    logic [W-1:0] nw;
    if (r) begin
      mq.delete();
      n_edges = 0;
      m_clean = '0; m_valid = 1'b0; m_chg = 1'b0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) run_len[i] = 0;
    end else begin
      so = (mq.size() == SS) ? mq[0] : '0;
      mq.push_back(raw);
      if (mq.size() > SS) void'(mq.pop_front());
      n_edges++;
      m_chg = 1'b0; m_rise = '0; m_fall = '0;
      if (n_edges == SS + 1) begin
        m_clean = so;
        m_valid = 1'b1;
      end else if (n_edges > SS + 1) begin
        nw = m_clean;
        for (int i = 0; i < W; i++) begin
          if (so[i] !== m_clean[i]) begin
            run_len[i]++;
            if (run_len[i] == DC) begin
              nw[i]      = so[i];
              run_len[i] = 0;
            end
          end else begin
            run_len[i] = 0;
          end
        end
        m_rise  = nw & ~m_clean;
        m_fall  = ~nw & m_clean;
        m_chg   = (nw != m_clean);
        m_clean = nw;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, sw_raw);
    #1;
    chk("clean",   32'(sw_clean),   32'(m_clean));
    chk("valid",   32'(sw_valid),   32'(m_valid));
    chk("changed", 32'(sw_changed), 32'(m_chg));
    chk("rise",    32'(sw_rise),    32'(m_rise));
    chk("fall",    32'(sw_fall),    32'(m_fall));
    if (sw_changed === 1'b1) begin
      ev_rise.push_back(sw_rise);
      ev_fall.push_back(sw_fall);
      ev_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic clear_events();
    ev_rise.delete();
    ev_fall.delete();
    ev_cyc.delete();
  endtask

  initial begin
    for (int i = 0; i < W; i++) run_len[i] = 0;
    n_edges = 0;

    // Startup: reset for two edges, then fill and load.
    rst    = 1'b1;
    sw_raw = 8'h0A;
    step();
    step();
    chk("t1_rst_clean", 32'(sw_clean), 32'h0);
    chk("t1_rst_valid", 32'(sw_valid), 32'h0);
    rst = 1'b0;
    clear_events();
    step();
    step();
    chk("t1_valid_early", 32'(sw_valid), 32'h0);
    step();
    chk("t1_valid", 32'(sw_valid), 32'h1);
    chk("t1_clean", 32'(sw_clean), 32'h0A);
    chk("t1_no_pulse", 32'(ev_cyc.size()), 32'd0);
    step();
    step();

    // Single bit rise, accepted on the sixth edge.
    sw_raw = 8'h0B;
    clear_events();
    repeat (5) step();
    chk("t2_before", 32'(sw_clean), 32'h0A);
    step();
    chk("t2_clean", 32'(sw_clean), 32'h0B);
    chk("t2_pulse", 32'(sw_changed), 32'h1);
    chk("t2_rise", 32'(sw_rise), 32'h01);
    chk("t2_fall", 32'(sw_fall), 32'h00);
    step();
    chk("t2_rise_after", 32'(sw_rise), 32'h00);
    chk("t2_fall_after", 32'(sw_fall), 32'h00);
    chk("t2_events", 32'(ev_cyc.size()), 32'd1);

    // Return to 0x0A, then a three-cycle glitch on bit 7.
    sw_raw = 8'h0A;
    repeat (8) step();
    clear_events();
    sw_raw = 8'h8A;
    repeat (3) step();
    sw_raw = 8'h0A;
    repeat (8) step();
    chk("t3_clean", 32'(sw_clean), 32'h0A);
    chk("t3_events", 32'(ev_cyc.size()), 32'd0);

    // All bits flip at once: one combined event.
    sw_raw = 8'hF5;
    clear_events();
    repeat (8) step();
    chk("t4_events", 32'(ev_cyc.size()), 32'd1);
    if (ev_cyc.size() == 1) begin
      chk("t4_rise", 32'(ev_rise[0]), 32'hF5);
      chk("t4_fall", 32'(ev_fall[0]), 32'h0A);
    end
    chk("t4_clean", 32'(sw_clean), 32'hF5);

    // Staggered bits: back-to-back events.
    sw_raw = 8'h00;
    repeat (8) step();
    clear_events();
    sw_raw = 8'h01;
    step();
    sw_raw = 8'h03;
    repeat (8) step();
    chk("t5_events", 32'(ev_cyc.size()), 32'd2);
    if (ev_cyc.size() == 2) begin
      chk("t5_rise0", 32'(ev_rise[0]), 32'h01);
      chk("t5_rise1", 32'(ev_rise[1]), 32'h02);
      chk("t5_gap", 32'(ev_cyc[1] - ev_cyc[0]), 32'd1);
    end

    // Reset in the middle of a pending change.
    sw_raw = 8'h0A;
    step();
    step();
    rst = 1'b1;
    clear_events();
    step();
    chk("t6_rst_clean", 32'(sw_clean), 32'h0);
    chk("t6_rst_valid", 32'(sw_valid), 32'h0);
    chk("t6_rst_rise", 32'(sw_rise), 32'h0);
    step();
    rst    = 1'b0;
    sw_raw = 8'h5C;
    repeat (3) step();
    chk("t6_valid", 32'(sw_valid), 32'h1);
    chk("t6_clean", 32'(sw_clean), 32'h5C);
    chk("t6_no_pulse", 32'(ev_cyc.size()), 32'd0);

    // Randomised holds, glitches and occasional resets against the model.
    repeat (60) begin
      int hold;
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) sw_raw = W'($urandom);
      else sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
      hold = $urandom_range(1, 7);
      repeat (hold) step();
    end
    sw_raw = W'($urandom);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_input_conditioner.md
Name: sw_input_conditioner

Overview:
- Input conditioning stage directly upstream of the RISC_8bit core's sw[7:0] port.
- Synchronises the raw board switches into the clk domain, debounces each bit independently, and presents a glitch-free word to the core.
- Also provides a one-cycle change strobe plus rise/fall masks, so program logic or a future interrupt path can react to switch events.
- Sequential block: per-bit sync chains, per-bit debounce counters, startup FSM.

Parameters:
- WIDTH, 8: number of switch bits.
- SYNC_STAGES, 2: synchroniser flops per bit. Must be >= 2.
- DEBOUNCE_CYCLES, 4: consecutive mismatching cycles required to accept a new level. Must be >= 1. Default is sized for simulation; board builds override it (e.g. 500000).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- sw_raw  in  WIDTH  asynchronous switch inputs from the pins.
- sw_clean  out  WIDTH  debounced switch word; drives the core's sw.
- sw_valid  out  1  high once sw_clean reflects the real switches after reset.
- sw_changed  out  1  one-cycle pulse when any bit of sw_clean changes in RUN.
- sw_rise  out  WIDTH  bits that went 0->1; valid only while sw_changed=1, else 0.
- sw_fall  out  WIDTH  bits that went 1->0; valid only while sw_changed=1, else 0.

Behaviour:
- Reset (rst=1 at a rising edge) clears all sync flops, stable register, counters and FSM counter. FSM goes to S_INIT.
- Reset values: sw_clean=0, sw_valid=0, sw_changed=0, sw_rise=0, sw_fall=0.
- Reset mid-debounce or mid-init discards all progress. No pulse is emitted.
- sync_out[i] is the last stage of bit i's chain. The chain shifts every cycle, including during INIT and LOAD.
- FSM:
  - S_INIT: counts SYNC_STAGES cycles to fill the chains, then goes to S_LOAD.
  - S_LOAD: for one cycle, stable <= sync_out directly. No sw_changed, no masks. Then goes to S_RUN.
  - S_RUN: stays in S_RUN until rst.
- sw_valid=1 exactly in S_RUN. It first rises SYNC_STAGES+1 edges after the edge where rst was sampled low.
- Per-bit debounce, S_RUN only:
  - If sync_out[i]==stable[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i] <= sync_out[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - cnt width = clog2(DEBOUNCE_CYCLES)+1. It never wraps.
- Any mismatch run shorter than DEBOUNCE_CYCLES cycles at sync_out is rejected: stable stays unchanged and the counter returns to 0.
- Latency: a level held on sw_raw from edge t0 appears on sw_clean after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. on the 6th edge with defaults.
- sw_clean = stable, registered, no combinational path from sw_raw.
- sw_changed is registered and asserted in the same cycle sw_clean takes its new value.
  - sw_rise = new & ~old; sw_fall = ~new & old, for that cycle only.
- Simultaneous events: bits are fully independent.
  - Bits accepting on the same edge produce a single sw_changed with combined masks.
  - Bits accepting on consecutive edges produce back-to-back pulses.
- A bit that toggles back before acceptance produces no event.
- A bit already debounced that reverts needs a fresh DEBOUNCE_CYCLES run.

Test Plan:
1. rst=1 for 2 edges, sw_raw=8'b00001010, release -> sw_valid rises on the 3rd edge after release; sw_clean=8'h0A on that edge; sw_changed never pulses during startup.
2. In RUN with sw_clean=8'h0A, sw_raw->8'h0B held -> sw_clean=8'h0B exactly 6 edges later; sw_changed=1 for one cycle; sw_rise=8'h01, sw_fall=8'h00; both masks 0 the next cycle.
3. Glitch: sw_raw bit 7 high for 3 cycles then low (8'h0A base) -> sw_clean stays 8'h0A; sw_changed stays 0 throughout.
4. sw_raw 8'h0A->8'hF5 in one cycle -> single sw_changed pulse after 6 edges; sw_rise=8'hF5, sw_fall=8'h0A, sw_clean=8'hF5.
5. Bit 0 driven high 1 cycle before bit 1 -> two consecutive sw_changed pulses with sw_rise=8'h01 then 8'h02 (base 8'h00).
6. Assert rst 2 cycles into a pending change -> all outputs 0 next edge; after release, startup repeats and sw_clean loads the current sw_raw with no pulse.
